// File: rtl/fir_filter_mac.sv
// Purpose: NUM_TAPS-tap direct-form FIR using one time-multiplexed multiplier, with run-time coefficients.
// Latency: sample accepted at edge E0 -> out_valid pulse in the cycle after edge E0+NUM_TAPS+1.
// Backpressure: in_ready is high only in IDLE; coefficient writes while busy are dropped and flagged.
module fir_filter_mac #(
    parameter int NUM_TAPS = 4,
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           x_in,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]           coef_wdata,
    output logic                        coef_drop,
    output logic [OUT_W-1:0]            y_out,
    output logic                        out_valid,
    output logic                        sat
);

    localparam int CW = $clog2(NUM_TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam int AW = PW + CW;
    // Extended width: room for the rounding add plus headroom over OUT_W for the clamp compare.
    localparam int EW = ((AW + 1 > OUT_W) ? AW + 1 : OUT_W) + 1;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EW-1:0] RND  = (SHIFT > 0) ? (EW'(1) << RS) : '0;
    localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CW-1:0]            cnt;
    logic signed [DATA_W-1:0] xd [NUM_TAPS];
    logic signed [COEF_W-1:0] h  [NUM_TAPS];
    logic signed [AW-1:0]     acc;
    logic signed [PW-1:0]     prod;
    logic signed [EW-1:0]     acc_ext;
    logic signed [EW-1:0]     rnd_sum;
    logic signed [EW-1:0]     r;
    logic [OUT_W-1:0]         y_nxt;
    logic                     sat_nxt;
    logic                     last_tap;
    logic                     addr_ok;

    assign last_tap = (cnt == CW'(NUM_TAPS - 1));
    assign addr_ok  = (int'(coef_addr) < NUM_TAPS);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MAC;
            end
            MAC:     if (last_tap) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single shared multiplier: tap cnt of the delay line against its coefficient.
    always_comb begin
        prod = h[cnt] * xd[cnt];
    end

    // Round half up, arithmetic shift, then clamp to the signed OUT_W range.
    always_comb begin
        acc_ext = {{(EW-AW){acc[AW-1]}}, acc};
        rnd_sum = acc_ext + RND;
        r       = rnd_sum >>> SHIFT;
        sat_nxt = 1'b0;
        y_nxt   = r[OUT_W-1:0];
        if (r > MAXV) begin
            y_nxt   = MAXV[OUT_W-1:0];
            sat_nxt = 1'b1;
        end else if (r < MINV) begin
            y_nxt   = MINV[OUT_W-1:0];
            sat_nxt = 1'b1;
        end
    end

    // Datapath: delay line, coefficient store, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                xd[k] <= '0;
                h[k]  <= COEF_W'(k + 1);
            end
            acc       <= '0;
            cnt       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            coef_drop <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sat       <= 1'b0;
            // A write outside IDLE is discarded; out-of-range addresses are silently ignored.
            coef_drop <= coef_we && addr_ok && (state != IDLE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = NUM_TAPS - 1; k > 0; k--) xd[k] <= xd[k-1];
                        xd[0] <= x_in;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                    // Same-edge write lands before the first MAC, so the new sample sees it.
                    if (coef_we && addr_ok) h[coef_addr] <= coef_wdata;
                end
                MAC: begin
                    acc <= acc + {{(AW-PW){prod[PW-1]}}, prod};
                    cnt <= cnt + 1'b1;
                end
                OUT: begin
                    y_out     <= y_nxt;
                    sat       <= sat_nxt;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_mac.sv
// Directed bench for fir_filter_mac: four instances share one stimulus bus; each test checks one of them.
// Instances: a = defaults, b = OUT_W 8, c = SHIFT 2, d = 3 taps.
// All stimulus changes and all sampling happen on the falling edge.
module tb_fir_filter_mac;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] x_in = '0;
    logic       coef_we = 1'b0;
    logic [1:0] coef_addr = '0;
    logic [7:0] coef_wdata = '0;

    logic a_rdy, a_drop, a_ov, a_sat; logic [15:0] a_y;
    logic b_rdy, b_drop, b_ov, b_sat; logic [7:0]  b_y;
    logic c_rdy, c_drop, c_ov, c_sat; logic [15:0] c_y;
    logic d_rdy, d_drop, d_ov, d_sat; logic [15:0] d_y;

    int errors = 0;
    int checks = 0;
    int sel = 0;
    logic rdy_s, ov_s, sat_s;
    int   y_s;

    always #5 clk = ~clk;

    fir_filter_mac dut_a (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_drop(a_drop),
        .y_out(a_y), .out_valid(a_ov), .sat(a_sat));
    fir_filter_mac #(.OUT_W(8)) dut_b (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_drop(b_drop),
        .y_out(b_y), .out_valid(b_ov), .sat(b_sat));
    fir_filter_mac #(.SHIFT(2)) dut_c (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_rdy), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_drop(c_drop),
        .y_out(c_y), .out_valid(c_ov), .sat(c_sat));
    fir_filter_mac #(.NUM_TAPS(3)) dut_d (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_rdy), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_drop(d_drop),
        .y_out(d_y), .out_valid(d_ov), .sat(d_sat));

    // Route the instance under test onto common observation signals.
    always_comb begin
        rdy_s = 1'b0; ov_s = 1'b0; sat_s = 1'b0; y_s = 0;
        case (sel)
            0: begin rdy_s = a_rdy; ov_s = a_ov; sat_s = a_sat; y_s = int'($signed(a_y)); end
            1: begin rdy_s = b_rdy; ov_s = b_ov; sat_s = b_sat; y_s = int'($signed(b_y)); end
            2: begin rdy_s = c_rdy; ov_s = c_ov; sat_s = c_sat; y_s = int'($signed(c_y)); end
            3: begin rdy_s = d_rdy; ov_s = d_ov; sat_s = d_sat; y_s = int'($signed(d_y)); end
            default: ;
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One reset edge; returns on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we = 1'b1; coef_addr = addr[1:0]; coef_wdata = val[7:0];
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Offer a sample (optionally with a coefficient write) until accepted; returns at the falling edge after acceptance.
    task automatic send(input int x, input logic cwe, input int caddr, input int cdata);
        int n;
        x_in = x[7:0]; in_valid = 1'b1;
        coef_we = cwe; coef_addr = caddr[1:0]; coef_wdata = cdata[7:0];
        n = 0;
        while (!rdy_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_s) check("accept_timeout", int'(rdy_s), 1);
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
    endtask

    // Wait for out_valid; lat counts edges after acceptance, low counts busy cycles seen.
    task automatic wait_out(output int y, output int s, output int lat, output int low);
        lat = 0; low = 0;
        while (!ov_s && lat < 60) begin
            if (!rdy_s) low++;
            @(negedge clk);
            lat++;
        end
        if (!ov_s) check("out_timeout", int'(ov_s), 1);
        y = y_s; s = int'(sat_s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int y, s, lat, low, acc_cnt, nout;
        int imp_x[5]   = '{1, 0, 0, 0, 0};
        int imp_y[5]   = '{1, 2, 3, 4, 0};
        int step_y[5]  = '{10, 30, 60, 100, 100};
        int sh_x[3]    = '{5, -5, 6};
        int sh_y[3]    = '{1, -1, 2};
        int got_y[5];

        // Reset state.
        sel = 0;
        do_reset();
        check("rst_in_ready", int'(a_rdy), 1);
        check("rst_out_valid", int'(a_ov), 0);
        check("rst_y_out", int'($signed(a_y)), 0);
        check("rst_sat", int'(a_sat), 0);
        check("rst_coef_drop", int'(a_drop), 0);

        // Impulse response with default taps, latency and busy window.
        for (int i = 0; i < 5; i++) begin
            send(imp_x[i], 1'b0, 0, 0);
            wait_out(y, s, lat, low);
            check($sformatf("impulse_y%0d", i), y, imp_y[i]);
            check($sformatf("impulse_sat%0d", i), s, 0);
            check($sformatf("impulse_lat%0d", i), lat, 5);
            check($sformatf("impulse_busy%0d", i), low, 5);
        end

        // Step with in_valid held: one acceptance every 6 cycles.
        do_reset();
        x_in = 8'd10; in_valid = 1'b1;
        acc_cnt = 0; nout = 0;
        for (int i = 0; i < 31; i++) begin
            if (a_rdy) acc_cnt++;
            if (a_ov && nout < 5) begin got_y[nout] = int'($signed(a_y)); nout++; end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("step_accepts", acc_cnt, 6);
        check("step_outputs", nout, 5);
        for (int i = 0; i < 5; i++) check($sformatf("step_y%0d", i), got_y[i], step_y[i]);

        // Saturation on the 8-bit output instance.
        sel = 1;
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, 127);
        for (int i = 0; i < 4; i++) begin
            send(127, 1'b0, 0, 0);
            wait_out(y, s, lat, low);
        end
        check("sat_pos_y", y, 127);
        check("sat_pos_flag", s, 1);
        for (int i = 0; i < 4; i++) begin
            send(-128, 1'b0, 0, 0);
            wait_out(y, s, lat, low);
        end
        check("sat_neg_y", y, -128);
        check("sat_neg_flag", s, 1);

        // Rounding with SHIFT=2 and h = 1,0,0,0.
        sel = 2;
        do_reset();
        for (int k = 1; k < 4; k++) write_coef(k, 0);
        for (int i = 0; i < 3; i++) begin
            send(sh_x[i], 1'b0, 0, 0);
            wait_out(y, s, lat, low);
            check($sformatf("round_y%0d", i), y, sh_y[i]);
            check($sformatf("round_sat%0d", i), s, 0);
        end

        // Coefficient write alongside a sample, then a rejected write during MAC.
        sel = 0;
        do_reset();
        send(2, 1'b1, 0, -3);
        wait_out(y, s, lat, low);
        check("coef_same_edge_y", y, -6);
        send(0, 1'b0, 0, 0);
        coef_we = 1'b1; coef_addr = 2'd1; coef_wdata = 8'd50;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_drop_pulse", int'(a_drop), 1);
        @(negedge clk);
        check("coef_drop_clear", int'(a_drop), 0);
        wait_out(y, s, lat, low);
        check("coef_unchanged_y", y, 4);

        // Out-of-range address on the 3-tap instance: ignored without a drop pulse.
        sel = 3;
        do_reset();
        write_coef(3, 50);
        check("oob_no_drop", int'(d_drop), 0);
        for (int i = 0; i < 3; i++) begin
            send(imp_x[i], 1'b0, 0, 0);
            wait_out(y, s, lat, low);
            check($sformatf("taps3_y%0d", i), y, imp_y[i]);
            if (i == 0) check("taps3_lat", lat, 4);
        end

        // Reset in the second MAC cycle.
        sel = 0;
        do_reset();
        send(1, 1'b1, 0, 9);
        wait_out(y, s, lat, low);
        check("pre_reset_y", y, 9);
        send(7, 1'b0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", int'(a_rdy), 1);
        check("midrst_out_valid", int'(a_ov), 0);
        check("midrst_y_out", int'($signed(a_y)), 0);
        for (int i = 0; i < 4; i++) begin
            send(imp_x[i], 1'b0, 0, 0);
            wait_out(y, s, lat, low);
            check($sformatf("midrst_imp_y%0d", i), y, imp_y[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
